// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - ALU op / result-group encodings and shared constants for the execute stage
package ex_stage_pkg;

    localparam int ALUOP_W    = 8;
    localparam int ALUSEL_W   = 3;
    localparam int REG_ADDR_W = 5;

    // ALU operations carried from ID/EX
    localparam logic [ALUOP_W-1:0] EX_AND_OP   = 8'h01;
    localparam logic [ALUOP_W-1:0] EX_OR_OP    = 8'h02;
    localparam logic [ALUOP_W-1:0] EX_XOR_OP   = 8'h03;
    localparam logic [ALUOP_W-1:0] EX_SLL_OP   = 8'h04;
    localparam logic [ALUOP_W-1:0] EX_SRL_OP   = 8'h05;
    localparam logic [ALUOP_W-1:0] EX_SRA_OP   = 8'h06;
    localparam logic [ALUOP_W-1:0] EX_ADD_OP   = 8'h07;
    localparam logic [ALUOP_W-1:0] EX_SUB_OP   = 8'h08;
    localparam logic [ALUOP_W-1:0] EX_SLT_OP   = 8'h09;
    localparam logic [ALUOP_W-1:0] EX_SLTU_OP  = 8'h0a;
    localparam logic [ALUOP_W-1:0] EX_LUI_OP   = 8'h0b;
    localparam logic [ALUOP_W-1:0] EX_AUIPC_OP = 8'h0c;
    localparam logic [ALUOP_W-1:0] EX_JAL_OP   = 8'h0d;
    localparam logic [ALUOP_W-1:0] EX_JALR_OP  = 8'h0e;
    localparam logic [ALUOP_W-1:0] EX_BEQ_OP   = 8'h0f;
    localparam logic [ALUOP_W-1:0] EX_BNE_OP   = 8'h10;
    localparam logic [ALUOP_W-1:0] EX_BLT_OP   = 8'h11;
    localparam logic [ALUOP_W-1:0] EX_BGE_OP   = 8'h12;
    localparam logic [ALUOP_W-1:0] EX_BLTU_OP  = 8'h13;
    localparam logic [ALUOP_W-1:0] EX_BGEU_OP  = 8'h14;
    localparam logic [ALUOP_W-1:0] EX_LB_OP    = 8'h15;
    localparam logic [ALUOP_W-1:0] EX_LH_OP    = 8'h16;
    localparam logic [ALUOP_W-1:0] EX_LW_OP    = 8'h17;
    localparam logic [ALUOP_W-1:0] EX_LBU_OP   = 8'h18;
    localparam logic [ALUOP_W-1:0] EX_LHU_OP   = 8'h19;
    localparam logic [ALUOP_W-1:0] EX_SB_OP    = 8'h1a;
    localparam logic [ALUOP_W-1:0] EX_SH_OP    = 8'h1b;
    localparam logic [ALUOP_W-1:0] EX_SW_OP    = 8'h1c;

    // Result groups
    localparam logic [ALUSEL_W-1:0] EX_RES_NOP    = 3'd0;
    localparam logic [ALUSEL_W-1:0] EX_RES_LOGIC  = 3'd1;
    localparam logic [ALUSEL_W-1:0] EX_RES_SHIFT  = 3'd2;
    localparam logic [ALUSEL_W-1:0] EX_RES_ARITH  = 3'd3;
    localparam logic [ALUSEL_W-1:0] EX_RES_JUMP   = 3'd4;
    localparam logic [ALUSEL_W-1:0] EX_RES_BRANCH = 3'd5;
    localparam logic [ALUSEL_W-1:0] EX_RES_MEM    = 3'd6;

    localparam logic [31:0]           ZeroWord     = 32'h0;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic [REG_ADDR_W-1:0] NOPRegAddr   = '0;

    // Stores never write the register file
    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
    endfunction

endpackage

// File: rtl/ex_stage_shifter.sv
// rtl/ex_stage_shifter.sv - 1-bit-per-cycle serial shifter with stall request
module serial_shifter
    import ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ALUOP_W-1:0] op,
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               hold,
    output logic               stall_req,
    output logic [XLEN-1:0]    result,
    output logic               idle
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} sh_state_t;

    sh_state_t          state;
    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] cnt;

    function automatic logic [XLEN-1:0] shift1(input logic [ALUOP_W-1:0] kind,
                                               input logic [XLEN-1:0] v);
        if (kind == EX_SLL_OP)
            return {v[XLEN-2:0], 1'b0};
        else if (kind == EX_SRA_OP)
            return {v[XLEN-1], v[XLEN-1:1]};
        else
            return {1'b0, v[XLEN-1:1]};
    endfunction

    // Operands stay stable while stalled, so they are captured only once in IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && shamt != '0) begin
                        acc   <= data;
                        cnt   <= shamt;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc <= shift1(op, acc);
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!hold)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stall covers the IDLE detect cycle plus every SHIFT cycle
    always_comb begin
        stall_req = rst && (((state == ST_IDLE) && start && (shamt != '0)) || (state == ST_SHIFT));
        result    = (state == ST_DONE) ? acc : data;
        idle      = (state == ST_IDLE);
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage: ALU, branch/jump resolution, load/store address
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [ALUSEL_W-1:0]   ex_alusel,
    input  logic [XLEN-1:0]       ex_r1_data,
    input  logic [XLEN-1:0]       ex_r2_data,
    input  logic                  ex_w_enable,
    input  logic [REG_ADDR_W-1:0] ex_w_addr,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic [XLEN-1:0]       ex_offset,
    input  logic [5:0]            stall,
    output logic [XLEN-1:0]       mem_w_data,
    output logic                  mem_w_enable,
    output logic [REG_ADDR_W-1:0] mem_w_addr,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_store_data,
    output logic                  ex_b_flag,
    output logic [XLEN-1:0]       ex_b_target,
    output logic                  stall_req_ex
);

    logic            sh_stall_req;
    logic            sh_idle;
    logic [XLEN-1:0] sh_result;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic            taken;

    serial_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start     (ex_alusel == EX_RES_SHIFT),
        .op        (ex_aluop),
        .data      (ex_r1_data),
        .shamt     (ex_r2_data[SHAMT_W-1:0]),
        .hold      (stall[3]),
        .stall_req (sh_stall_req),
        .result    (sh_result),
        .idle      (sh_idle)
    );

    // Comparisons shared by SLT/SLTU and the conditional branches
    always_comb begin
        lt_s  = $signed(ex_r1_data) < $signed(ex_r2_data);
        lt_u  = ex_r1_data < ex_r2_data;
        eq    = ex_r1_data == ex_r2_data;
        taken = 1'b0;
        case (ex_aluop)
            EX_BEQ_OP:  taken = eq;
            EX_BNE_OP:  taken = !eq;
            EX_BLT_OP:  taken = lt_s;
            EX_BGE_OP:  taken = !lt_s;
            EX_BLTU_OP: taken = lt_u;
            EX_BGEU_OP: taken = !lt_u;
            default:    taken = 1'b0;
        endcase
    end

    // Result selection by group; a NOP group or reset leaves everything at zero
    always_comb begin
        mem_w_data     = ZeroWord;
        mem_w_enable   = WriteDisable;
        mem_w_addr     = NOPRegAddr;
        mem_aluop      = '0;
        mem_addr       = ZeroWord;
        mem_store_data = ZeroWord;
        ex_b_flag      = 1'b0;
        ex_b_target    = ZeroWord;
        stall_req_ex   = sh_stall_req;
        if (rst && ex_alusel != EX_RES_NOP) begin
            mem_w_enable = ex_w_enable;
            mem_w_addr   = ex_w_addr;
            mem_aluop    = ex_aluop;
            case (ex_alusel)
                EX_RES_LOGIC: begin
                    case (ex_aluop)
                        EX_AND_OP: mem_w_data = ex_r1_data & ex_r2_data;
                        EX_OR_OP:  mem_w_data = ex_r1_data | ex_r2_data;
                        EX_XOR_OP: mem_w_data = ex_r1_data ^ ex_r2_data;
                        default:   mem_w_data = ZeroWord;
                    endcase
                end
                EX_RES_SHIFT: mem_w_data = sh_result;
                EX_RES_ARITH: begin
                    case (ex_aluop)
                        EX_ADD_OP:   mem_w_data = ex_r1_data + ex_r2_data;
                        EX_SUB_OP:   mem_w_data = ex_r1_data - ex_r2_data;
                        EX_SLT_OP:   mem_w_data = {{(XLEN-1){1'b0}}, lt_s};
                        EX_SLTU_OP:  mem_w_data = {{(XLEN-1){1'b0}}, lt_u};
                        EX_LUI_OP:   mem_w_data = ex_r2_data;
                        EX_AUIPC_OP: mem_w_data = ex_pc + ex_r2_data;
                        default:     mem_w_data = ZeroWord;
                    endcase
                end
                EX_RES_JUMP: begin
                    mem_w_data  = ex_pc + XLEN'(4);
                    ex_b_flag   = sh_idle;
                    ex_b_target = (ex_aluop == EX_JALR_OP)
                                ? ((ex_r1_data + ex_offset) & ~XLEN'(1))
                                : (ex_pc + ex_offset);
                end
                EX_RES_BRANCH: begin
                    mem_w_enable = WriteDisable;
                    ex_b_flag    = taken && sh_idle;
                    ex_b_target  = ex_pc + ex_offset;
                end
                EX_RES_MEM: begin
                    mem_addr       = ex_r1_data + ex_offset;
                    mem_store_data = ex_r2_data;
                    if (is_store(ex_aluop))
                        mem_w_enable = WriteDisable;
                end
                default: mem_w_enable = WriteDisable;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed-vector bench for ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [31:0] ex_r1_data, ex_r2_data, ex_pc, ex_offset;
    logic        ex_w_enable;
    logic [4:0]  ex_w_addr;
    logic [5:0]  stall;
    logic [31:0] mem_w_data, mem_addr, mem_store_data, ex_b_target;
    logic        mem_w_enable, ex_b_flag, stall_req_ex;
    logic [4:0]  mem_w_addr;
    logic [7:0]  mem_aluop;

    int vectors = 0;
    int miscompares = 0;
    int n_stall;
    logic left_stall;

    ex_stage #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_r1_data(ex_r1_data), .ex_r2_data(ex_r2_data), .ex_w_enable(ex_w_enable),
        .ex_w_addr(ex_w_addr), .ex_pc(ex_pc), .ex_offset(ex_offset), .stall(stall),
        .mem_w_data(mem_w_data), .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr),
        .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
        .ex_b_flag(ex_b_flag), .ex_b_target(ex_b_target), .stall_req_ex(stall_req_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] off);
        ex_alusel  = sel;
        ex_aluop   = op;
        ex_r1_data = a;
        ex_r2_data = b;
        ex_pc      = p;
        ex_offset  = off;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stall_req_ex cycles from the current cycle until it drops (bounded)
    task automatic count_stall(output int n, output logic ended);
        n = 0;
        ended = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            #1;
            if (stall_req_ex) begin
                n++;
                tick();
            end else begin
                ended = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        stall = 6'b0;
        ex_w_enable = 1'b1;
        ex_w_addr = 5'd7;
        drive(EX_RES_ARITH, EX_ADD_OP, 32'h7fffffff, 32'h1, 32'h0, 32'h0);
        tick();
        #1;
        check("rst w_data", mem_w_data, 32'h0);
        check("rst w_en", {31'b0, mem_w_enable}, 32'h0);
        check("rst w_addr", {27'b0, mem_w_addr}, 32'h0);
        check("rst stall", {31'b0, stall_req_ex}, 32'h0);
        tick();
        rst = 1'b1;

        #1;
        check("add ovf", mem_w_data, 32'h80000000);
        check("add w_en", {31'b0, mem_w_enable}, 32'h1);
        check("add w_addr", {27'b0, mem_w_addr}, 32'h7);
        check("add stall", {31'b0, stall_req_ex}, 32'h0);
        drive(EX_RES_ARITH, EX_SUB_OP, 32'h5, 32'h7, 32'h0, 32'h0);           #1 check("sub", mem_w_data, 32'hfffffffe);
        drive(EX_RES_ARITH, EX_SLT_OP, 32'hffffffff, 32'h1, 32'h0, 32'h0);    #1 check("slt", mem_w_data, 32'h1);
        drive(EX_RES_ARITH, EX_SLTU_OP, 32'hffffffff, 32'h1, 32'h0, 32'h0);   #1 check("sltu", mem_w_data, 32'h0);
        drive(EX_RES_ARITH, EX_LUI_OP, 32'h9, 32'habcde000, 32'h0, 32'h0);    #1 check("lui", mem_w_data, 32'habcde000);
        drive(EX_RES_ARITH, EX_AUIPC_OP, 32'h9, 32'h5000, 32'h1000, 32'h0);   #1 check("auipc", mem_w_data, 32'h6000);
        drive(EX_RES_LOGIC, EX_XOR_OP, 32'hf0f0, 32'hff00, 32'h0, 32'h0);     #1 check("xor", mem_w_data, 32'h0ff0);
        drive(EX_RES_LOGIC, EX_AND_OP, 32'hf0f0, 32'hff00, 32'h0, 32'h0);     #1 check("and", mem_w_data, 32'hf000);

        drive(EX_RES_BRANCH, EX_BEQ_OP, 32'h55, 32'h55, 32'h100, 32'h20);
        #1;
        check("beq flag", {31'b0, ex_b_flag}, 32'h1);
        check("beq target", ex_b_target, 32'h120);
        check("beq w_en", {31'b0, mem_w_enable}, 32'h0);
        drive(EX_RES_BRANCH, EX_BNE_OP, 32'h55, 32'h55, 32'h100, 32'h20);     #1 check("bne flag", {31'b0, ex_b_flag}, 32'h0);
        drive(EX_RES_BRANCH, EX_BLT_OP, 32'hffffffff, 32'h1, 32'h100, 32'h20); #1 check("blt flag", {31'b0, ex_b_flag}, 32'h1);
        drive(EX_RES_BRANCH, EX_BLTU_OP, 32'hffffffff, 32'h1, 32'h100, 32'h20); #1 check("bltu flag", {31'b0, ex_b_flag}, 32'h0);

        drive(EX_RES_JUMP, EX_JALR_OP, 32'h1003, 32'h0, 32'h300, 32'h4);
        #1;
        check("jalr target", ex_b_target, 32'h1006);
        check("jalr link", mem_w_data, 32'h304);
        check("jalr flag", {31'b0, ex_b_flag}, 32'h1);
        drive(EX_RES_JUMP, EX_JAL_OP, 32'h1003, 32'h0, 32'h200, 32'h40);      #1 check("jal target", ex_b_target, 32'h240);

        drive(EX_RES_MEM, EX_LW_OP, 32'h1000, 32'h0, 32'h0, 32'h8);
        #1;
        check("lw addr", mem_addr, 32'h1008);
        check("lw w_en", {31'b0, mem_w_enable}, 32'h1);
        check("lw w_data", mem_w_data, 32'h0);
        drive(EX_RES_MEM, EX_SW_OP, 32'h1000, 32'hdead, 32'h0, 32'hfffffffc);
        #1;
        check("sw addr", mem_addr, 32'h0ffc);
        check("sw data", mem_store_data, 32'hdead);
        check("sw w_en", {31'b0, mem_w_enable}, 32'h0);
        drive(EX_RES_NOP, EX_ADD_OP, 32'h3, 32'h4, 32'h0, 32'h0);
        #1;
        check("nop w_data", mem_w_data, 32'h0);
        check("nop w_en", {31'b0, mem_w_enable}, 32'h0);

        // shamt field zero (upper r2 bits ignored): same-cycle pass-through, no stall
        tick();
        drive(EX_RES_SHIFT, EX_SLL_OP, 32'h77, 32'h20, 32'h0, 32'h0);
        #1;
        check("sll0 data", mem_w_data, 32'h77);
        check("sll0 stall", {31'b0, stall_req_ex}, 32'h0);
        tick();
        check("sll0 stall next", {31'b0, stall_req_ex}, 32'h0);

        // SRA by 4: five stall cycles, then DONE, then IDLE
        drive(EX_RES_SHIFT, EX_SRA_OP, 32'h80000000, 32'h4, 32'h0, 32'h0);
        count_stall(n_stall, left_stall);
        check("sra ended", {31'b0, left_stall}, 32'h1);
        check("sra stall cycles", n_stall, 32'd5);
        check("sra result", mem_w_data, 32'hf8000000);
        tick();
        drive(EX_RES_SHIFT, EX_SLL_OP, 32'h1234, 32'h0, 32'h0, 32'h0);
        #1;
        check("sra idle after", mem_w_data, 32'h1234);
        check("sra idle stall", {31'b0, stall_req_ex}, 32'h0);

        // reset while shifting with cnt at 3
        tick();
        drive(EX_RES_SHIFT, EX_SLL_OP, 32'h1, 32'h5, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst mid stall", {31'b0, stall_req_ex}, 32'h0);
        check("rst mid data", mem_w_data, 32'h0);
        tick();
        check("rst hold stall", {31'b0, stall_req_ex}, 32'h0);
        rst = 1'b1;
        drive(EX_RES_SHIFT, EX_SLL_OP, 32'habcd, 32'h0, 32'h0, 32'h0);
        #1;
        check("rst idle stall", {31'b0, stall_req_ex}, 32'h0);
        check("rst idle data", mem_w_data, 32'habcd);

        // stall[3] high from the start: shifting continues, DONE holds
        tick();
        stall = 6'b001100;
        drive(EX_RES_SHIFT, EX_SRL_OP, 32'h80, 32'h2, 32'h0, 32'h0);
        count_stall(n_stall, left_stall);
        check("srl ended", {31'b0, left_stall}, 32'h1);
        check("srl stall cycles", n_stall, 32'd3);
        check("srl result", mem_w_data, 32'h20);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("hold data", mem_w_data, 32'h20);
            check("hold stall", {31'b0, stall_req_ex}, 32'h0);
        end
        stall = 6'b0;
        tick();
        drive(EX_RES_SHIFT, EX_SLL_OP, 32'h55, 32'h0, 32'h0, 32'h0);
        #1;
        check("release data", mem_w_data, 32'h55);
        check("release stall", {31'b0, stall_req_ex}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
